if_stage: RTL and testbench

- Instruction-fetch stage; sits directly upstream of the decode stage.
- Owns the PC register and issues one fetch at a time to instruction memory over a req/gnt/rvalid handshake.
- Drives the IF/ID pipeline register (instr, pc, pc+4, valid) consumed by decode.
- Honours the pipeline stall and branch/jump redirects from EX, discarding any in-flight or buffered fetch on redirect.

---
 rtl/if_stage.sv | 144 ++++++++++++++
 tb/tb_if_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage. Owns the PC, issues one fetch at a time over a
// req/gnt/rvalid handshake and drives the IF/ID register consumed by decode.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   stall               hold IF/ID and suppress PC advance
//   redirect_en/_pc     one-cycle flush and refetch from redirect_pc (word aligned)
//   imem_req/addr       fetch request and word address
//   imem_gnt            request accepted this cycle
//   imem_rvalid/rdata   in-order read response, at least one cycle after grant
//   if_id_instr/pc/pc_4/valid  IF/ID pipeline register (valid=0 means bubble)
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_4,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {StFetch, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] buf_q, buf_d;
  logic        kill_q, kill_d;
  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] req_pc_4;

  assign req_pc_4  = req_pc_q + 32'd4;
  assign imem_req  = (state_q == StFetch) && !rst;
  assign imem_addr = pc_q & ~32'd3;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    buf_d         = buf_q;
    kill_d        = kill_q;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;

    unique case (state_q)
      StFetch: begin
        if (imem_gnt) begin
          req_pc_d = pc_q;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          if (kill_q) begin
            // Response to a request orphaned by an earlier redirect.
            kill_d  = 1'b0;
            state_d = StFetch;
          end else if (!stall) begin
            deliver = 1'b1;
            pc_d    = req_pc_4;
            state_d = StFetch;
          end else begin
            buf_d   = imem_rdata;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (!stall) begin
          deliver       = 1'b1;
          deliver_instr = buf_q;
          pc_d          = req_pc_4;
          state_d       = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase

    // Redirect overrides everything above, including stall.
    if (redirect_en) begin
      pc_d    = redirect_pc & ~32'd3;
      deliver = 1'b0;
      unique case (state_q)
        StFetch: begin
          // A grant this cycle leaves one response in flight that must be dropped.
          kill_d  = imem_gnt;
          state_d = imem_gnt ? StWait : StFetch;
        end
        StWait: begin
          kill_d  = !imem_rvalid;
          state_d = imem_rvalid ? StFetch : StWait;
        end
        default: begin
          kill_d  = 1'b0;
          state_d = StFetch;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      buf_q       <= '0;
      kill_q      <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
      if_id_pc_4  <= '0;
      if_id_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      buf_q    <= buf_d;
      kill_q   <= kill_d;
      if (redirect_en || !stall) begin
        if (deliver) begin
          if_id_instr <= deliver_instr;
          if_id_pc    <= req_pc_q;
          if_id_pc_4  <= req_pc_4;
          if_id_valid <= 1'b1;
        end else begin
          // Bubble: pc fields keep their last value.
          if_id_instr <= NOP_INSTR;
          if_id_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect_en, imem_gnt, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_instr, if_id_pc, if_id_pc_4;

  always #5 clk = ~clk;

  if_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_id_instr(if_id_instr),
    .if_id_pc   (if_id_pc),
    .if_id_pc_4 (if_id_pc_4),
    .if_id_valid(if_id_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;
  int dly_min  = 1;
  int dly_max  = 1;

  // Memory model: at most one outstanding request.
  bit          out_v;
  bit          out_stale;
  int          out_dly;
  logic [31:0] out_addr;

  // Program-order reference: next PC due on IF/ID, and whether its word has arrived.
  logic [31:0] exp_pc;
  bit          avail;
  logic [31:0] exp_instr, exp_ifpc, exp_ifpc4;
  logic        exp_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, expv, $time);
    end
  endtask

  task automatic reset_model();
    out_v     = 1'b0;
    out_stale = 1'b0;
    out_dly   = 0;
    out_addr  = '0;
    exp_pc    = RESET_PC;
    avail     = 1'b0;
    exp_instr = NOP;
    exp_ifpc  = '0;
    exp_ifpc4 = '0;
    exp_valid = 1'b0;
  endtask

  task automatic check_reset();
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_instr", if_id_instr,          NOP);
    chk("rst_pc",    if_id_pc,             32'd0);
    chk("rst_pc4",   if_id_pc_4,           32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
  endtask

  task automatic check_outputs();
    chk("instr", if_id_instr,          exp_instr);
    chk("pc",    if_id_pc,             exp_ifpc);
    chk("pc4",   if_id_pc_4,           exp_ifpc4);
    chk("valid", {31'd0, if_id_valid}, {31'd0, exp_valid});
    // A request is issued exactly when nothing is in flight or waiting to be delivered.
    chk("req",   {31'd0, imem_req},    {31'd0, !(out_v || avail)});
    if (imem_req) chk("addr", imem_addr, exp_pc);
  endtask

  // One clock cycle, entered and left at a falling edge.
  // gmode: 0 never grant, 1 always grant, 2 random grant plus stray rvalid.
  task automatic cyc(input bit st, input bit rd, input logic [31:0] tgt, input int gmode);
    bit ret;
    bit ret_stale;
    check_outputs();
    ret         = 1'b0;
    ret_stale   = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (out_v) begin
      out_dly--;
      if (out_dly <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(out_addr);
        ret         = 1'b1;
        ret_stale   = out_stale;
        out_v       = 1'b0;
      end
    end
    imem_gnt = imem_req && (gmode == 1 || (gmode == 2 && $urandom_range(0, 1) == 1));
    if (gmode == 2 && imem_req && $urandom_range(0, 7) == 0) imem_rvalid = 1'b1;
    stall       = st;
    redirect_en = rd;
    redirect_pc = tgt;

    if (imem_gnt) begin
      out_v     = 1'b1;
      out_stale = rd;
      out_addr  = imem_addr;
      out_dly   = $urandom_range(dly_max, dly_min);
    end else if (rd && out_v) begin
      out_stale = 1'b1;
    end

    if (rd) begin
      avail     = 1'b0;
      exp_pc    = tgt & ~32'd3;
      exp_instr = NOP;
      exp_valid = 1'b0;
    end else begin
      if (ret && !ret_stale) avail = 1'b1;
      if (!st) begin
        if (avail) begin
          exp_instr = mem_word(exp_pc);
          exp_ifpc  = exp_pc;
          exp_ifpc4 = exp_pc + 32'd4;
          exp_valid = 1'b1;
          exp_pc    = exp_pc + 32'd4;
          avail     = 1'b0;
          n_deliv++;
        end else begin
          exp_instr = NOP;
          exp_valid = 1'b0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    reset_model();
    @(negedge clk);
    check_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Straight-line fetch: 0, 4, 8 with bubbles between.
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 32'd0, 1);
    chk("seq_pc",    if_id_pc,             32'h8);
    chk("seq_pc4",   if_id_pc_4,           32'hC);
    chk("seq_valid", {31'd0, if_id_valid}, 32'd1);

    // Response returns under a 3-cycle stall and is held in the buffer.
    cyc(1'b0, 1'b0, 32'd0, 1);
    cyc(1'b1, 1'b0, 32'd0, 1);
    cyc(1'b1, 1'b0, 32'd0, 1);
    cyc(1'b1, 1'b0, 32'd0, 1);
    chk("hold_pc",  if_id_pc,          32'h8);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1);
    chk("unhold_pc",   if_id_pc,  32'hC);
    chk("unhold_addr", imem_addr, 32'h10);

    // Redirect in the grant cycle orphans the 0x10 fetch.
    cyc(1'b0, 1'b1, 32'h100, 1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'd0, 1);
    chk("redir_pc",    if_id_pc,             32'h100);
    chk("redir_valid", {31'd0, if_id_valid}, 32'd1);

    // Redirect while stalled in the buffered state.
    cyc(1'b0, 1'b0, 32'd0, 1);
    cyc(1'b1, 1'b0, 32'd0, 1);
    cyc(1'b1, 1'b1, 32'h200, 1);
    chk("hredir_valid", {31'd0, if_id_valid}, 32'd0);
    chk("hredir_instr", if_id_instr,          NOP);
    chk("hredir_addr",  imem_addr,            32'h200);
    cyc(1'b0, 1'b0, 32'd0, 1);
    cyc(1'b0, 1'b0, 32'd0, 1);
    chk("hredir_pc", if_id_pc, 32'h200);

    // Misaligned target and PC wrap.
    cyc(1'b0, 1'b1, 32'h103, 0);
    chk("align_addr", imem_addr, 32'h100);
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 0);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'd0, 1);
    cyc(1'b0, 1'b0, 32'd0, 1);
    chk("wrap_pc",   if_id_pc,   32'hFFFF_FFFC);
    chk("wrap_pc4",  if_id_pc_4, 32'h0);
    chk("wrap_addr", imem_addr,  32'h0);

    // Back-to-back redirects while one slow response is in flight.
    dly_min = 4;
    dly_max = 4;
    cyc(1'b0, 1'b0, 32'd0, 1);
    dly_min = 1;
    dly_max = 1;
    cyc(1'b0, 1'b1, 32'h300, 1);
    cyc(1'b0, 1'b1, 32'h400, 1);
    cyc(1'b0, 1'b0, 32'd0, 1);
    cyc(1'b0, 1'b0, 32'd0, 1);
    chk("b2b_addr", imem_addr, 32'h400);
    cyc(1'b0, 1'b0, 32'd0, 1);
    cyc(1'b0, 1'b0, 32'd0, 1);
    chk("b2b_pc", if_id_pc, 32'h400);

    // Asynchronous reset between clock edges while waiting for a response.
    dly_min = 3;
    dly_max = 3;
    for (int i = 0; i < 20 && !out_v; i++) cyc(1'b0, 1'b0, 32'd0, 1);
    chk("pre_rst_wait", {31'd0, out_v}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset();
    reset_model();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    #1;
    chk("post_rst_req",  {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr,         RESET_PC);

    // Randomized traffic against the reference.
    dly_min = 1;
    dly_max = 3;
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, $urandom, 2);
    end
    chk("progress", {31'd0, n_deliv > 150}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
